// File: rtl/useq_pkg.sv
// Shared definitions for the microsequencer: next-address codes and FSM state encoding.
package useq_pkg;

    localparam logic [2:0] SEQ_NEXT     = 3'd0;
    localparam logic [2:0] SEQ_JUMP     = 3'd1;
    localparam logic [2:0] SEQ_BZ       = 3'd2;
    localparam logic [2:0] SEQ_BC       = 3'd3;
    localparam logic [2:0] SEQ_CALL     = 3'd4;
    localparam logic [2:0] SEQ_RET      = 3'd5;
    localparam logic [2:0] SEQ_DISPATCH = 3'd6;
    localparam logic [2:0] SEQ_HALT     = 3'd7;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2
    } useq_state_e;

endpackage

// File: rtl/useq_stack.sv
// Synchronous LIFO of return addresses; top-of-stack is visible combinationally on dout.
module useq_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int SP_W = $clog2(DEPTH + 1);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]    mem [0:(1<<AW)-1];
    logic [SP_W-1:0] sp;
    logic [AW-1:0]   top_idx;

    assign full    = (sp == SP_W'(DEPTH));
    assign empty   = (sp == '0);
    assign top_idx = AW'(sp - SP_W'(1));
    assign dout    = mem[top_idx];

    // Push and pop never coincide from the sequencer; push wins if they did.
    always_ff @(posedge clk) begin
        if (clear) begin
            sp <= '0;
        end else if (push && !full) begin
            mem[AW'(sp)] <= din;
            sp           <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

endmodule

// File: rtl/useq_engine.sv
// Microsequencer: maps opcodes to microroutines and steps the micro-PC through control memory.
// Optional USEQ_PERF_EN adds saturating accepted-instruction and EXEC-cycle counters.
module useq_engine
    import useq_pkg::*;
#(
    parameter int OPC_W       = 8,
    parameter int UADDR_W     = 6,
    parameter int MAP_SHIFT   = 2,
    parameter int STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               flag_z,
    input  logic               flag_c,
    input  logic [2:0]         seq_op,
    input  logic [UADDR_W-1:0] seq_target,
    output logic [UADDR_W-1:0] uaddr,
    output logic               uvalid,
    output logic               halted,
`ifdef USEQ_PERF_EN
    output logic [15:0]        instr_count,
    output logic [31:0]        ucycle_count,
`endif
    output logic               err
);

    useq_state_e state, next_state;
    logic [UADDR_W-1:0] next_uaddr, uaddr_inc, stk_top;
    logic [OPC_W+MAP_SHIFT-1:0] shifted;
    logic next_err, push, pop, stk_clear, stk_full, stk_empty, accept;

    assign shifted     = (OPC_W + MAP_SHIFT)'(opcode) << MAP_SHIFT;
    assign uaddr_inc   = uaddr + UADDR_W'(1);
    assign instr_ready = (state == ST_FETCH);
    assign uvalid      = (state == ST_EXEC);
    assign halted      = (state == ST_HALTED);
    assign accept      = instr_ready && instr_valid;
    assign stk_clear   = reset || (uvalid && seq_op == SEQ_DISPATCH);

    useq_stack #(.DEPTH(STACK_DEPTH), .W(UADDR_W)) u_stack (
        .clk   (clk),
        .push  (push),
        .pop   (pop),
        .clear (stk_clear),
        .din   (uaddr_inc),
        .dout  (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        next_state = state;
        next_uaddr = uaddr;
        next_err   = err;
        push       = 1'b0;
        pop        = 1'b0;
        case (state)
            ST_FETCH: begin
                if (instr_valid) begin
                    next_uaddr = UADDR_W'(shifted);
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (seq_op)
                    SEQ_NEXT: next_uaddr = uaddr_inc;
                    SEQ_JUMP: next_uaddr = seq_target;
                    SEQ_BZ:   next_uaddr = flag_z ? seq_target : uaddr_inc;
                    SEQ_BC:   next_uaddr = flag_c ? seq_target : uaddr_inc;
                    SEQ_CALL: begin
                        if (stk_full) begin
                            next_err   = 1'b1;
                            next_state = ST_HALTED;
                        end else begin
                            push       = 1'b1;
                            next_uaddr = seq_target;
                        end
                    end
                    SEQ_RET: begin
                        if (stk_empty) begin
                            next_err   = 1'b1;
                            next_state = ST_HALTED;
                        end else begin
                            pop        = 1'b1;
                            next_uaddr = stk_top;
                        end
                    end
                    SEQ_DISPATCH: begin
                        next_uaddr = '0;
                        next_state = ST_FETCH;
                    end
                    default: next_state = ST_HALTED;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
            uaddr <= '0;
            err   <= 1'b0;
        end else begin
            state <= next_state;
            uaddr <= next_uaddr;
            err   <= next_err;
        end
    end

`ifdef USEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count  <= '0;
            ucycle_count <= '0;
        end else begin
            if (accept && instr_count != 16'hFFFF)
                instr_count <= instr_count + 16'd1;
            if (uvalid && ucycle_count != 32'hFFFF_FFFF)
                ucycle_count <= ucycle_count + 32'd1;
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule
